boolean_seq: RTL and testbench
==============================

Name: boolean_seq

Overview:
- Sequencer for the 8-bit boolean logic block. Accepts a stream of commands (opcode + 8-bit operand) through a valid/ready interface and buffers them in a small FIFO.
- Executes each command against an internal 8-bit accumulator by driving the external boolean block's opcode/a/b inputs and capturing its result.
- When a command marked last completes, presents the accumulator on a result valid/ready port.
- Sits between a command source (testbench or controller) and the boolean datapath.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept the command.
- cmd_op  input  4  opcode: 0000 LOAD, 0101 AND, 0110 OR, 0111 XOR, 1000 NOT; anything else is illegal.
- cmd_data  input  8  operand.
- cmd_last  input  1  final command of a sequence.
- alu_opcode  output  4  to boolean block opcode.
- alu_a  output  8  to boolean block a.
- alu_b  output  8  to boolean block b.
- alu_res  input  8  from boolean block res (combinational).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  8  accumulator value.
- res_err  output  1  an illegal opcode occurred in this sequence.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - FIFO empties; state goes to IDLE; accumulator = 0; err = 0.
  - res_valid = 0, res_data = 0, res_err = 0, alu_* = 0.
  - cmd_ready = 0 while rst is high.
  - Reset mid-sequence discards all buffered and in-flight commands.
- FIFO handshake:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full (combinational), qualified by !rst.
  - A push while full is not accepted, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Pushes are accepted in every state, including DONE.
- FSM (IDLE, EXEC, DONE):
  - IDLE: alu_* = 0. If FIFO is non-empty, pop the head into cur_op/cur_data/cur_last and go to EXEC.
  - EXEC: drive alu_opcode = cur_op, alu_a = acc, alu_b = cur_data (combinational from registers). At the clock edge:
    - LOAD: acc <= cur_data.
    - Any other opcode: acc <= alu_res.
    - Illegal opcode: the datapath returns 0, so acc becomes 0 and err <= 1.
    - Next state is DONE if cur_last, else IDLE.
  - DONE:
    - res_valid = 1, res_data = acc, res_err = err; alu_* = 0.
    - On res_ready: acc <= 0, err <= 0, go to IDLE.
    - res_valid is held with stable data until accepted.
- Latency:
  - Each command takes 2 cycles (IDLE pop + EXEC), minimum.
  - A command pushed into an empty FIFO in cycle N is popped in cycle N+1 and executed in N+2. res_valid rises in N+3 if that command is last.
  - Back-to-back sequences with res_ready held high lose 1 cycle per result (the DONE cycle).
- NOT ignores cur_data; alu_b is still driven with cur_data.
- A sequence without LOAD starts from acc = 0.

Optional Feature:
- BOOL_SEQ_PARITY_EN defined:
  - Adds output res_parity (1 bit), equal to the XOR reduction of res_data, valid whenever res_valid is high.
  - res_parity is 0 at reset and whenever res_valid is low.
- Not defined: no res_parity port; all other behaviour identical.

Test Plan:
- Reset with FIFO holding 3 commands -> after rst deasserts, FIFO empty, res_valid = 0, acc = 0, all alu_* = 0, cmd_ready = 1.
- Push LOAD 0xF0, AND 0x3C, OR 0x01, XOR 0xFF (last) with res_ready = 1 -> alu_opcode sequence 0000/0101/0110/0111 seen in EXEC cycles; res_data = 0xCE, res_err = 0; res_valid high exactly 1 cycle.
- Push LOAD 0x5A, NOT (last) with res_ready = 0 for 5 cycles -> res_data = 0xA5 held stable with res_valid = 1 until res_ready rises; then acc = 0.
- Push LOAD 0x77, op 0011, OR 0x08 (last) -> res_data = 0x08, res_err = 1; res_err = 0 on the next sequence.
- Hold cmd_valid = 1 continuously with res_ready = 0 while in DONE -> exactly DEPTH = 4 commands are accepted, cmd_ready drops to 0, no overwrite; after res_ready, draining restores cmd_ready and all 4 execute in order.
- With BOOL_SEQ_PARITY_EN: LOAD 0x07 (last) -> res_data = 0x07, res_parity = 1. LOAD 0x03 (last) -> res_parity = 0.

Source files
------------

// File: rtl/boolean_seq.sv
// Command sequencer for the 8-bit boolean block: FIFO-buffered commands run against an accumulator.
// Optional `BOOL_SEQ_PARITY_EN adds res_parity (XOR reduction of res_data while res_valid).
module boolean_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_res,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err
`ifdef BOOL_SEQ_PARITY_EN
  ,
  output logic       res_parity
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [7:0]    acc_q, acc_d;
  logic          err_q, err_d;
  logic [3:0]    cur_op_q, cur_op_d;
  logic [7:0]    cur_data_q, cur_data_d;
  logic          cur_last_q, cur_last_d;

  logic        full, empty, push, pop, legal_op;
  logic [12:0] head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q];
  assign legal_op  = cur_op_q inside {OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_NOT};

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    state_d    = state_q;
    acc_d      = acc_q;
    err_d      = err_q;
    cur_op_d   = cur_op_q;
    cur_data_d = cur_data_q;
    cur_last_d = cur_last_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_op_d   = head[12:9];
          cur_data_d = head[8:1];
          cur_last_d = head[0];
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        // Illegal opcodes rely on the datapath returning 0 for the accumulator.
        acc_d   = (cur_op_q == OP_LOAD) ? cur_data_q : alu_res;
        err_d   = err_q || !legal_op;
        state_d = cur_last_q ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (res_ready) begin
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (state_q == S_EXEC) begin
      alu_opcode = cur_op_q;
      alu_a      = acc_q;
      alu_b      = cur_data_q;
    end
    res_valid = (state_q == S_DONE);
    res_data  = res_valid ? acc_q : '0;
    res_err   = res_valid && err_q;
  end

`ifdef BOOL_SEQ_PARITY_EN
  assign res_parity = ^res_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      acc_q      <= '0;
      err_q      <= 1'b0;
      cur_op_q   <= '0;
      cur_data_q <= '0;
      cur_last_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      cur_op_q   <= cur_op_d;
      cur_data_q <= cur_data_d;
      cur_last_q <= cur_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_last};
  end

endmodule

// File: tb/tb_boolean_seq.sv
// Bench for boolean_seq: directed latency/full/reset cases plus random traffic scored against a
// command-level accumulator model; the boolean block itself is modelled combinationally here.
module tb_boolean_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_last;
  logic [3:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       res_valid, res_ready, res_err;
  logic [7:0] res_data;
`ifdef BOOL_SEQ_PARITY_EN
  logic       res_parity;
`endif

  always #5 clk = ~clk;

  boolean_seq #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
`ifdef BOOL_SEQ_PARITY_EN
    , .res_parity(res_parity)
`endif
  );

  // External boolean block; opcode 0000 passes a through, illegal codes yield 0.
  function automatic logic [7:0] bool_block(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    case (op)
      4'b0000: return a;
      4'b0101: return a & b;
      4'b0110: return a | b;
      4'b0111: return a ^ b;
      4'b1000: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_res = bool_block(alu_opcode, alu_a, alu_b);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sequence result computed at command acceptance time.
  logic [7:0] m_acc = '0;
  logic       m_err = 1'b0;
  logic [8:0] exp_q [$];

  task automatic model_cmd(input logic [3:0] op, input logic [7:0] data, input logic last);
    case (op)
      4'b0000: m_acc = data;
      4'b0101: m_acc = m_acc & data;
      4'b0110: m_acc = m_acc | data;
      4'b0111: m_acc = m_acc ^ data;
      4'b1000: m_acc = ~m_acc;
      default: begin m_acc = 8'h00; m_err = 1'b1; end
    endcase
    if (last) begin
      exp_q.push_back({m_err, m_acc});
      m_acc = '0;
      m_err = 1'b0;
    end
  endtask

  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_e;

  always @(negedge clk) begin
    if (rst) begin
      m_acc = '0;
      m_err = 1'b0;
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_eq("res_hold_valid", {31'd0, res_valid}, 32'd1);
        check_eq("res_hold_data", {24'd0, res_data}, {24'd0, hold_d});
        check_eq("res_hold_err", {31'd0, res_err}, {31'd0, hold_e});
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_result", {31'd0, res_valid}, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check_eq("res_data", {24'd0, res_data}, {24'd0, e[7:0]});
          check_eq("res_err", {31'd0, res_err}, {31'd0, e[8]});
        end
      end
`ifdef BOOL_SEQ_PARITY_EN
      check_eq("res_parity", {31'd0, res_parity}, {31'd0, res_valid && (^res_data)});
`endif
      if (cmd_valid && cmd_ready) model_cmd(cmd_op, cmd_data, cmd_last);
      hold_v = res_valid && !res_ready;
      hold_d = res_data;
      hold_e = res_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] data, input logic last);
    logic ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_last = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) check_eq("push_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen = res_valid;
      tick();
      if (seen) break;
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic drain(input string tag);
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_eq(tag, exp_q.size(), 32'd0);
    repeat (2) tick();
  endtask

  logic [3:0] t2_op [4] = '{4'h0, 4'h5, 4'h6, 4'h7};
  logic [7:0] t2_b  [4] = '{8'hF0, 8'h3C, 8'h01, 8'hFF};
  logic [7:0] t2_a  [4] = '{8'h00, 8'hF0, 8'h30, 8'h31};
  logic [3:0] rnd_ops [7] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h8, 4'h3, 4'hF};

  initial begin
    int acc_cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_last = 1'b0;
    res_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("init_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("init_res", {23'd0, res_err, res_data}, 32'd0);
    check_eq("init_alu", {12'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    check_eq("init_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();

    // Reset with three commands buffered behind a pending result.
    push_cmd(4'h0, 8'h42, 1'b1);
    wait_valid("t1_wait");
    push_cmd(4'h5, 8'h0F, 1'b0);
    push_cmd(4'h6, 8'h10, 1'b0);
    push_cmd(4'h7, 8'h01, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t1_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    rst = 1'b0;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      check_eq("t1_res_valid", {31'd0, res_valid}, 32'd0);
      check_eq("t1_alu", {12'd0, alu_opcode, alu_a, alu_b}, 32'd0);
      check_eq("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      tick();
    end
    push_cmd(4'h7, 8'h3C, 1'b1);
    drain("t1_drain");

    // Back-to-back four-command sequence with exact latency.
    res_ready = 1'b1;
    for (int w = 0; w <= 10; w++) begin
      if (w < 4) begin
        cmd_valid = 1'b1; cmd_op = t2_op[w]; cmd_data = t2_b[w]; cmd_last = (w == 3);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (w < 4) check_eq("t2_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      if (w >= 2 && w <= 8 && (w % 2) == 0)
        check_eq("t2_alu_exec", {12'd0, alu_opcode, alu_a, alu_b},
                 {12'd0, t2_op[w/2-1], t2_a[w/2-1], t2_b[w/2-1]});
      else if (w >= 1)
        check_eq("t2_alu_idle", {12'd0, alu_opcode, alu_a, alu_b}, 32'd0);
      if (w >= 8) check_eq("t2_res_valid", {31'd0, res_valid}, {31'd0, w == 9});
      if (w == 9) check_eq("t2_res_data", {24'd0, res_data}, 32'hCE);
      tick();
    end
    drain("t2_drain");

    // Result held while the consumer stalls.
    res_ready = 1'b0;
    push_cmd(4'h0, 8'h5A, 1'b0);
    push_cmd(4'h8, 8'h33, 1'b1);
    wait_valid("t3_wait");
    repeat (5) tick();
    @(negedge clk);
    check_eq("t3_res_data", {24'd0, res_data}, 32'hA5);
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("t3_valid_drop", {31'd0, res_valid}, 32'd0);
    tick();
    push_cmd(4'h6, 8'h00, 1'b1);
    drain("t3_drain");

    // Illegal opcode sets err for that sequence only.
    push_cmd(4'h0, 8'h77, 1'b0);
    push_cmd(4'h3, 8'hAA, 1'b0);
    push_cmd(4'h6, 8'h08, 1'b1);
    push_cmd(4'h5, 8'hFF, 1'b1);
    drain("t4_drain");

    // FIFO fills while a result is pending.
    res_ready = 1'b0;
    push_cmd(4'h0, 8'h11, 1'b1);
    wait_valid("t5_wait");
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'h0; cmd_data = 8'h20 + 8'(i); cmd_last = 1'b1;
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc_cnt++;
      tick();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_full_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("t5_accepted", acc_cnt, 32'd4);
    tick();
    drain("t5_drain");
    @(negedge clk);
    check_eq("t5_ready_back", {31'd0, cmd_ready}, 32'd1);
    tick();

    push_cmd(4'h0, 8'h07, 1'b1);
    drain("t6_drain_a");
    push_cmd(4'h0, 8'h03, 1'b1);
    drain("t6_drain_b");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = rnd_ops[$urandom_range(0, 6)];
      cmd_data  = 8'($urandom);
      cmd_last  = ($urandom_range(0, 3) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    push_cmd(4'h6, 8'h00, 1'b1);
    drain("rnd_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
